// File: rtl/byte_ram.sv
`default_nettype none
// ============================================================================
// Module   : byte_ram
// Purpose  : Single-port byte/word RAM with valid/ready request, registered
//            response stage and error reporting. Define RAM_CLEAR_EN to
//            zero-fill the array after every reset.
// Revision : 1.0 - initial release
// ============================================================================
module byte_ram #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 9,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic              req_byte,
   input  logic              req_sext,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic              busy
);

   localparam int LANES     = DATA_W / 8;
   localparam int LANE_BITS = $clog2(LANES);
   localparam int IDX_W     = ADDR_W - LANE_BITS;
   localparam int MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W:0] DEPTH_LIM = (IDX_W + 1)'(DEPTH);

   logic [DATA_W-1:0]    r_mem [DEPTH];
   logic                 r_rsp_valid;
   logic [DATA_W-1:0]    r_rsp_data;
   logic                 r_rsp_err;

   logic                 w_run;
   logic                 w_accept;
   logic [IDX_W-1:0]     w_idx;
   logic [MEM_AW-1:0]    w_mem_idx;
   logic [LANE_BITS-1:0] w_lane;
   logic                 w_err;
   logic [DATA_W-1:0]    w_rword;
   logic [7:0]           w_rbyte;
   logic [DATA_W-1:0]    w_rd_result;
   logic [MEM_AW-1:0]    w_wr_idx;
   logic [DATA_W-1:0]    w_wr_data;
   logic [LANES-1:0]     w_wr_lane;

`ifdef RAM_CLEAR_EN
   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t              r_state;
   logic [MEM_AW-1:0]   r_clr_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= ST_CLEAR;
         r_clr_cnt <= '0;
      end else if (r_state == ST_CLEAR) begin
         r_clr_cnt <= r_clr_cnt + 1'b1;
         if (r_clr_cnt == MEM_AW'(DEPTH - 1)) begin
            r_state <= ST_RUN;
         end
      end
   end

   assign w_run = (r_state == ST_RUN);
`else
   assign w_run = 1'b1;
`endif

   assign busy      = !w_run;
   assign req_ready = w_run && (!r_rsp_valid || rsp_ready);
   assign w_accept  = req_valid && req_ready;

   assign w_idx     = req_addr[ADDR_W-1:LANE_BITS];
   assign w_mem_idx = w_idx[MEM_AW-1:0];
   assign w_lane    = req_addr[LANE_BITS-1:0];
   assign w_err     = (!req_byte && (w_lane != '0)) || ({1'b0, w_idx} >= DEPTH_LIM);

   assign w_rword = r_mem[w_mem_idx];
   assign w_rbyte = w_rword[8*w_lane +: 8];

   always_comb begin
      w_rd_result = '0;
      if (!w_err && !req_we) begin
         if (req_byte) begin
            w_rd_result = {{(DATA_W-8){req_sext & w_rbyte[7]}}, w_rbyte};
         end else begin
            w_rd_result = w_rword;
         end
      end
   end

   // Byte writes replicate the byte onto every lane and enable only the target lane.
   always_comb begin
      w_wr_idx  = w_mem_idx;
      w_wr_data = req_byte ? {LANES{req_wdata[7:0]}} : req_wdata;
      w_wr_lane = '0;
      if (w_accept && req_we && !w_err) begin
         for (int l = 0; l < LANES; l++) begin
            w_wr_lane[l] = !req_byte || (w_lane == LANE_BITS'(l));
         end
      end
`ifdef RAM_CLEAR_EN
      if (r_state == ST_CLEAR) begin
         w_wr_idx  = r_clr_cnt;
         w_wr_data = '0;
         w_wr_lane = '1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      for (int l = 0; l < LANES; l++) begin
         if (w_wr_lane[l]) begin
            r_mem[w_wr_idx][8*l +: 8] <= w_wr_data[8*l +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
      end else if (w_accept) begin
         r_rsp_valid <= 1'b1;
         r_rsp_data  <= w_rd_result;
         r_rsp_err   <= w_err;
      end else if (r_rsp_valid && rsp_ready) begin
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_byte_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_byte_ram
// Purpose  : Self-checking bench for byte_ram (DATA_W=16, DEPTH=256 plus a
//            DEPTH=128 instance for range errors). Honours RAM_CLEAR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_byte_ram;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_we = 1'b0, req_byte = 1'b0, req_sext = 1'b0;
   logic [8:0]  req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic        rsp_ready = 1'b1;
   logic        req_ready, rsp_valid, rsp_err, busy;
   logic [15:0] rsp_data;
   logic        req_ready2, rsp_valid2, rsp_err2, busy2;
   logic [15:0] rsp_data2;

   always #5 clk = ~clk;

   byte_ram #(.DATA_W(16), .ADDR_W(9), .DEPTH(256)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_byte(req_byte), .req_sext(req_sext), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy));

   byte_ram #(.DATA_W(16), .ADDR_W(9), .DEPTH(128)) u_dut128 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready2),
      .req_we(req_we), .req_byte(req_byte), .req_sext(req_sext), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data2), .rsp_err(rsp_err2), .busy(busy2));

   int checks = 0;
   int errors = 0;

   // Byte-addressed little-endian image of the 256-word memory.
   logic [7:0] m_mem [512];

   typedef struct packed { logic [15:0] d; logic e; } rsp_t;
   rsp_t exp_q[$];

   typedef struct {
      logic        we;
      logic        is_byte;
      logic        sext;
      logic [8:0]  addr;
      logic [15:0] wdata;
      logic [15:0] exp_d;
      logic        exp_e;
   } vec_t;
   vec_t tbl[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
      end
   endtask

   function automatic void model(input logic we, input logic is_byte, input logic sext,
                                 input logic [8:0] addr, input logic [15:0] wd,
                                 output logic [15:0] d, output logic e);
      logic [7:0] b;
      int a;
      a = int'(addr);
      e = (!is_byte && addr[0]) || ((a / 2) >= 256);
      d = 16'h0000;
      if (!e) begin
         if (we) begin
            m_mem[a] = wd[7:0];
            if (!is_byte) m_mem[a + 1] = wd[15:8];
         end else if (is_byte) begin
            b = m_mem[a];
            d = sext ? {{8{b[7]}}, b} : {8'h00, b};
         end else begin
            d = {m_mem[a + 1], m_mem[a]};
         end
      end
   endfunction

   task automatic set_req(input logic we, input logic is_byte, input logic sext,
                          input logic [8:0] addr, input logic [15:0] wd);
      req_we = we; req_byte = is_byte; req_sext = sext; req_addr = addr; req_wdata = wd;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic idle();
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // One isolated request with rsp_ready=1; returns the captured response.
   task automatic do_req(input logic we, input logic is_byte, input logic sext,
                         input logic [8:0] addr, input logic [15:0] wd,
                         output logic [15:0] d, output logic e);
      int n = 0;
      set_req(we, is_byte, sext, addr, wd);
      req_valid = 1'b1;
      rsp_ready = 1'b1;
      @(negedge clk);
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("rsp_valid", rsp_valid, 1);
      d = rsp_data;
      e = rsp_err;
   endtask

   task automatic count_busy(output int n, output int ready_seen);
      n = 0;
      ready_seen = 0;
      while (busy && n < 1000) begin
         n++;
         if (req_ready) ready_seen++;
         @(negedge clk);
      end
   endtask

   initial begin
      logic [15:0] d, md;
      logic        e, me;
      int          n, rs;
      logic        accepted_last, stall_prev, held_e;
      logic [15:0] held_d;
      logic [8:0]  bp_a[4];
      logic [15:0] bp_e[4];

      tbl[0]  = '{1'b1, 1'b0, 1'b0, 9'h010, 16'hA55A, 16'h0000, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 9'h011, 16'hFF3C, 16'h0000, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 9'h010, 16'h0000, 16'h3C5A, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 1'b1, 9'h011, 16'h0000, 16'h003C, 1'b0};
      tbl[4]  = '{1'b1, 1'b1, 1'b0, 9'h010, 16'h0080, 16'h0000, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 1'b1, 9'h010, 16'h0000, 16'hFF80, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 9'h010, 16'h0000, 16'h0080, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 9'h010, 16'h0000, 16'h3C80, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 1'b0, 9'h012, 16'hBEEF, 16'h0000, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 1'b0, 9'h013, 16'h1111, 16'h0000, 1'b1};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 9'h012, 16'h0000, 16'hBEEF, 1'b0};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 9'h013, 16'h0000, 16'h0000, 1'b1};
      tbl[12] = '{1'b0, 1'b1, 1'b0, 9'h013, 16'h0000, 16'h00BE, 1'b0};
      tbl[13] = '{1'b0, 1'b1, 1'b1, 9'h012, 16'h0000, 16'hFFEF, 1'b0};

      // Reset values
      do_reset();
`ifdef RAM_CLEAR_EN
      set_req(1'b0, 1'b0, 1'b0, 9'h1FE, 16'h0000);
      req_valid = 1'b1;
`endif
      @(negedge clk);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_err", rsp_err, 0);
`ifdef RAM_CLEAR_EN
      chk("rst_busy", busy, 1);
      chk("rst_req_ready", req_ready, 0);
      count_busy(n, rs);
      chk("clear_cycles", n, 256);
      chk("ready_during_clear", rs, 0);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("clear_rd_valid", rsp_valid, 1);
      chk("clear_rd_1FE", rsp_data, 16'h0000);

      // Reset pulse part-way through the clear restarts it
      do_reset();
      repeat (100) @(posedge clk);
      @(negedge clk);
      chk("midclear_busy", busy, 1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      count_busy(n, rs);
      chk("midclear_restart_cycles", n, 256);
      for (int i = 0; i < 512; i++) m_mem[i] = 8'h00;
      do_req(1'b0, 1'b0, 1'b0, 9'h0A0, 16'h0000, d, e);
      chk("clear_rd_0A0", d, 16'h0000);
`else
      chk("rst_busy", busy, 0);
      chk("rst_req_ready", req_ready, 1);
`endif
      chk("busy2_run", busy2, 0);

      // Give every word a known value
      for (int i = 0; i < 256; i++) begin
         md = 16'($urandom);
         model(1'b1, 1'b0, 1'b0, 9'(2 * i), md, d, e);
         do_req(1'b1, 1'b0, 1'b0, 9'(2 * i), md, d, e);
      end
      chk("init_last_err", e, 0);

      // Directed vectors
      for (int i = 0; i < 14; i++) begin
         model(tbl[i].we, tbl[i].is_byte, tbl[i].sext, tbl[i].addr, tbl[i].wdata, md, me);
         do_req(tbl[i].we, tbl[i].is_byte, tbl[i].sext, tbl[i].addr, tbl[i].wdata, d, e);
         chk($sformatf("vec%0d_data", i), d, tbl[i].exp_d);
         chk($sformatf("vec%0d_err", i), e, tbl[i].exp_e);
      end

      // Write immediately followed by a read of the same word
      idle();
      set_req(1'b1, 1'b0, 1'b0, 9'h020, 16'h1234);
      req_valid = 1'b1;
      model(1'b1, 1'b0, 1'b0, 9'h020, 16'h1234, md, me);
      @(negedge clk);
      chk("wr_rd_ready", req_ready, 1);
      @(posedge clk);
      #1 set_req(1'b0, 1'b0, 1'b0, 9'h020, 16'h0000);
      @(negedge clk);
      chk("wr_rsp_data", rsp_data, 16'h0000);
      chk("wr_rsp_err", rsp_err, 0);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("wr_rd_valid", rsp_valid, 1);
      chk("wr_rd_data", rsp_data, 16'h1234);

      // Range error on the 128-word instance
      model(1'b0, 1'b0, 1'b0, 9'h100, 16'h0000, md, me);
      do_req(1'b0, 1'b0, 1'b0, 9'h100, 16'h0000, d, e);
      chk("rd100_main_data", d, md);
      chk("rd100_main_err", e, 0);
      chk("rd100_d128_valid", rsp_valid2, 1);
      chk("rd100_d128_err", rsp_err2, 1);
      chk("rd100_d128_data", rsp_data2, 16'h0000);
      do_req(1'b0, 1'b0, 1'b0, 9'h0FE, 16'h0000, d, e);
      chk("rd0FE_d128_err", rsp_err2, 0);
      chk("rd0FE_d128_data", rsp_data2, d);

      // Back-pressure: four back-to-back reads, response stalled three cycles
      bp_a[0] = 9'h010; bp_a[1] = 9'h012; bp_a[2] = 9'h020; bp_a[3] = 9'h014;
      for (int k = 0; k < 4; k++) model(1'b0, 1'b0, 1'b0, bp_a[k], 16'h0000, bp_e[k], me);
      idle();
      rsp_ready = 1'b0;
      set_req(1'b0, 1'b0, 1'b0, bp_a[0], 16'h0000);
      req_valid = 1'b1;
      @(negedge clk);
      chk("bp_first_ready", req_ready, 1);
      @(posedge clk);
      #1 req_addr = bp_a[1];
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_stall_ready", req_ready, 0);
         chk("bp_stall_valid", rsp_valid, 1);
         chk("bp_stall_data", rsp_data, bp_e[0]);
         @(posedge clk);
         #1;
      end
      rsp_ready = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk("bp_flow_ready", req_ready, 1);
         chk($sformatf("bp_order%0d", k - 1), rsp_data, bp_e[k - 1]);
         @(posedge clk);
         #1;
         if (k < 3) req_addr = bp_a[k + 1];
         else req_valid = 1'b0;
      end
      @(negedge clk);
      chk("bp_last_valid", rsp_valid, 1);
      chk("bp_order3", rsp_data, bp_e[3]);

      // Randomised pipelined traffic against the model
      idle();
      accepted_last = 1'b1;
      stall_prev = 1'b0;
      held_d = '0;
      held_e = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc >= 2990) begin
            req_valid = 1'b0;
            rsp_ready = 1'b1;
         end else begin
            if (!req_valid || accepted_last) begin
               req_valid = ($urandom_range(0, 3) != 0);
               req_we    = $urandom_range(0, 1) == 1;
               req_byte  = $urandom_range(0, 1) == 1;
               req_sext  = $urandom_range(0, 1) == 1;
               req_addr  = 9'($urandom_range(0, 511));
               if (!req_byte && $urandom_range(0, 7) != 0) req_addr[0] = 1'b0;
               req_wdata = 16'($urandom);
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
         end
         @(negedge clk);
         chk("rnd_rsp_valid", rsp_valid, (exp_q.size() != 0));
         chk("rnd_req_ready", req_ready, (exp_q.size() == 0) || rsp_ready);
         if (stall_prev) begin
            chk("rnd_hold_data", rsp_data, held_d);
            chk("rnd_hold_err", rsp_err, held_e);
         end
         accepted_last = req_valid && ((exp_q.size() == 0) || rsp_ready);
         stall_prev = (exp_q.size() != 0) && !rsp_ready;
         held_d = rsp_data;
         held_e = rsp_err;
         if ((exp_q.size() != 0) && rsp_ready) begin
            chk("rnd_data", rsp_data, exp_q[0].d);
            chk("rnd_err", rsp_err, exp_q[0].e);
            void'(exp_q.pop_front());
         end
         if (accepted_last) begin
            model(req_we, req_byte, req_sext, req_addr, req_wdata, md, me);
            exp_q.push_back('{d: md, e: me});
         end
         @(posedge clk);
         #1;
      end
      chk("rnd_drained", exp_q.size(), 0);

      // Reset drops a pending response
      idle();
      rsp_ready = 1'b0;
      set_req(1'b0, 1'b0, 1'b0, 9'h012, 16'h0000);
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("pend_valid", rsp_valid, 1);
      do_reset();
      @(negedge clk);
      chk("pend_dropped_valid", rsp_valid, 0);
      chk("pend_dropped_data", rsp_data, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
